// File: rtl/status_register_cond.sv
// NZCV flag register ({Z,C,N,V} order) with ARM condition-code evaluation for the ID stage.
// Optional same-cycle flag forwarding from the ALU is enabled by defining FLAG_BYPASS_EN.
module status_register_cond #(
  parameter int STATUS_WIDTH = 4
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset,
  input  logic                    i_EX_Valid,
  input  logic                    i_EX_S,
  input  logic [STATUS_WIDTH-1:0] i_Status,
  input  logic                    i_Stall,
  input  logic [3:0]              i_ID_Cond,
  output logic [STATUS_WIDTH-1:0] o_Status,
  output logic                    o_Carry,
  output logic                    o_Cond_Pass,
  output logic                    o_Flag_Hazard
);

  localparam logic [3:0] COND_AL  = 4'b1110;
  localparam logic [3:0] COND_RSV = 4'b1111;

  logic [STATUS_WIDTH-1:0] status_q;
  logic [STATUS_WIDTH-1:0] status_d;
  logic                    pend;
  logic                    upd_en;
  logic [STATUS_WIDTH-1:0] flags_src;

  // Condition evaluation on a {Z,C,N,V} flag vector.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
    logic z, c, n, v;
    logic res;
    z = f[3];
    c = f[2];
    n = f[1];
    v = f[0];
    res = 1'b0;
    case (cond)
      4'b0000: res = z;
      4'b0001: res = ~z;
      4'b0010: res = c;
      4'b0011: res = ~c;
      4'b0100: res = n;
      4'b0101: res = ~n;
      4'b0110: res = v;
      4'b0111: res = ~v;
      4'b1000: res = c & ~z;
      4'b1001: res = ~c | z;
      4'b1010: res = (n == v);
      4'b1011: res = (n != v);
      4'b1100: res = ~z & (n == v);
      4'b1101: res = z | (n != v);
      4'b1110: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  assign pend   = i_EX_Valid & i_EX_S;
  assign upd_en = pend & ~i_Stall;

  always_comb begin
    status_d = status_q;
    if (upd_en) begin
      status_d = i_Status;
    end
  end

  // Flag register stage: a stalled update is simply re-presented by EX later.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      status_q <= '0;
    end else begin
      status_q <= status_d;
    end
  end

  assign o_Status = status_q;
  assign o_Carry  = status_q[2];

`ifdef FLAG_BYPASS_EN
  assign flags_src     = pend ? i_Status : status_q;
  assign o_Flag_Hazard = 1'b0;
`else
  assign flags_src     = status_q;
  assign o_Flag_Hazard = pend & (i_ID_Cond != COND_AL) & (i_ID_Cond != COND_RSV);
`endif

  assign o_Cond_Pass = cond_eval(i_ID_Cond, flags_src);

endmodule
